// File: rtl/puzzle_move_ctrl.sv
// puzzle_move_ctrl: applies one slide move of the 3x3 sliding puzzle to an
// external 256x8 register file. Reads the blank position and depth counters,
// validates the move, swaps the blank with its neighbour and then commits the
// new position and move count. Owns the register file ports while busy.
module puzzle_move_ctrl #(
  parameter logic [7:0] POS_ADDR   = 8'h03,
  parameter logic [7:0] COUNT_ADDR = 8'h0B,
  parameter logic [7:0] MAXD_ADDR  = 8'h0C,
  parameter logic [7:0] BOARD_BASE = 8'h10,
  parameter logic [7:0] BLANK_CODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] dir,
  input  logic [7:0] rf_outa,
  input  logic [7:0] rf_outb,
  output logic [7:0] rf_src0,
  output logic [7:0] rf_src1,
  output logic [7:0] rf_dst,
  output logic       rf_we,
  output logic [7:0] rf_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [3:0] blank_pos
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_POS   = 4'd1;
  localparam logic [3:0] S_RD_LIM   = 4'd2;
  localparam logic [3:0] S_RD_TILE  = 4'd3;
  localparam logic [3:0] S_WR_TILE  = 4'd4;
  localparam logic [3:0] S_WR_BLANK = 4'd5;
  localparam logic [3:0] S_WR_POS   = 4'd6;
  localparam logic [3:0] S_WR_CNT   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ILLEGAL = 2'd1;
  localparam logic [1:0] ST_DEPTH   = 2'd2;
  localparam logic [1:0] ST_BADPOS  = 2'd3;

  logic [3:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] p_q, p_d;          // blank position before the move
  logic [3:0] np_q, np_d;        // blank position after the move
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tile_q, tile_d;
  logic [1:0] status_q, status_d;
  logic [3:0] blank_pos_q, blank_pos_d;

  // Column of the freshly read position (only meaningful when it is 0..8)
  logic [3:0] rd_p;
  logic [1:0] rd_col;
  logic       rd_illegal;
  logic [3:0] rd_np;

  // Decode the read position into column, legality and target cell
  always_comb begin
    rd_p = rf_outa[3:0];
    case (rd_p)
      4'd0, 4'd3, 4'd6: rd_col = 2'd0;
      4'd1, 4'd4, 4'd7: rd_col = 2'd1;
      default:          rd_col = 2'd2;
    endcase
    rd_illegal = 1'b0;
    rd_np      = rd_p;
    case (dir_q)
      DIR_UP: begin
        rd_illegal = (rd_p < 4'd3);
        rd_np      = rd_p - 4'd3;
      end
      DIR_RIGHT: begin
        rd_illegal = (rd_col == 2'd2);
        rd_np      = rd_p + 4'd1;
      end
      DIR_DOWN: begin
        rd_illegal = (rd_p > 4'd5);
        rd_np      = rd_p + 4'd3;
      end
      default: begin
        rd_illegal = (rd_col == 2'd0);
        rd_np      = rd_p - 4'd1;
      end
    endcase
  end

  // Next-state and latched-value logic for the move sequencer
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    p_d         = p_q;
    np_d        = np_q;
    cnt_d       = cnt_q;
    tile_d      = tile_q;
    status_d    = status_q;
    blank_pos_d = blank_pos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          state_d = S_RD_POS;
        end
      end
      S_RD_POS: begin
        p_d = rd_p;
        if (rf_outa > 8'd8) begin
          status_d = ST_BADPOS;
          state_d  = S_DONE;
        end else if (rd_illegal) begin
          status_d = ST_ILLEGAL;
          state_d  = S_DONE;
        end else begin
          np_d    = rd_np;
          state_d = S_RD_LIM;
        end
      end
      S_RD_LIM: begin
        cnt_d = rf_outa;
        if (rf_outa >= rf_outb) begin
          status_d = ST_DEPTH;
          state_d  = S_DONE;
        end else begin
          state_d = S_RD_TILE;
        end
      end
      S_RD_TILE: begin
        tile_d  = rf_outa;
        state_d = S_WR_TILE;
      end
      S_WR_TILE:  state_d = S_WR_BLANK;
      S_WR_BLANK: state_d = S_WR_POS;
      S_WR_POS:   state_d = S_WR_CNT;
      S_WR_CNT: begin
        status_d    = ST_OK;
        blank_pos_d = np_q;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register file port decode, driven purely from state and latched values
  always_comb begin
    rf_src0 = 8'd0;
    rf_src1 = 8'd0;
    rf_dst  = 8'd0;
    rf_we   = 1'b0;
    rf_data = 8'd0;
    case (state_q)
      S_RD_POS: rf_src0 = POS_ADDR;
      S_RD_LIM: begin
        rf_src0 = COUNT_ADDR;
        rf_src1 = MAXD_ADDR;
      end
      S_RD_TILE: rf_src0 = BOARD_BASE + {4'd0, np_q};
      S_WR_TILE: begin
        rf_we   = 1'b1;
        rf_dst  = BOARD_BASE + {4'd0, p_q};
        rf_data = tile_q;
      end
      S_WR_BLANK: begin
        rf_we   = 1'b1;
        rf_dst  = BOARD_BASE + {4'd0, np_q};
        rf_data = BLANK_CODE;
      end
      S_WR_POS: begin
        rf_we   = 1'b1;
        rf_dst  = POS_ADDR;
        rf_data = {4'd0, np_q};
      end
      S_WR_CNT: begin
        rf_we   = 1'b1;
        rf_dst  = COUNT_ADDR;
        rf_data = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 2'd0;
      p_q         <= 4'd0;
      np_q        <= 4'd0;
      cnt_q       <= 8'd0;
      tile_q      <= 8'd0;
      status_q    <= ST_OK;
      blank_pos_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      p_q         <= p_d;
      np_q        <= np_d;
      cnt_q       <= cnt_d;
      tile_q      <= tile_d;
      status_q    <= status_d;
      blank_pos_q <= blank_pos_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign status    = status_q;
  assign blank_pos = blank_pos_q;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// tb_puzzle_move_ctrl: directed bench for puzzle_move_ctrl with a behavioural
// 256x8 register file (combinational reads, write on the clock edge).
module tb_puzzle_move_ctrl;

  localparam int POS   = 8'h03;
  localparam int COUNT = 8'h0B;
  localparam int MAXD  = 8'h0C;
  localparam int BB    = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [7:0] rf_outa, rf_outb;
  logic [7:0] rf_src0, rf_src1, rf_dst, rf_data;
  logic       rf_we, busy, done;
  logic [1:0] status;
  logic [3:0] blank_pos;

  logic [7:0] rf [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'd0;
  logic [7:0] bd_data = 8'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file: backdoor preload from the bench, otherwise DUT writes
  always @(posedge clk) begin
    if (bd_we) rf[bd_addr] <= bd_data;
    else if (rf_we) rf[rf_dst] <= rf_data;
  end
  assign rf_outa = rf[rf_src0];
  assign rf_outb = rf[rf_src1];

  puzzle_move_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .rf_outa(rf_outa), .rf_outb(rf_outb),
    .rf_src0(rf_src0), .rf_src1(rf_src1), .rf_dst(rf_dst),
    .rf_we(rf_we), .rf_data(rf_data),
    .busy(busy), .done(done), .status(status), .blank_pos(blank_pos)
  );

  task automatic poke(input int addr, input int data);
    bd_addr = addr[7:0];
    bd_data = data[7:0];
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Issues one move from IDLE; reports done cycle (-1 if none) and rf_we cycles
  task automatic run_move(input logic [1:0] d, output int done_cyc, output logic [31:0] we_mask);
    done_cyc = -1;
    we_mask  = 32'd0;
    dir   = d;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (rf_we) we_mask[c] = 1'b1;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, status, blank_pos} !== 8'd0) begin
      failures++;
      $display("FAIL reset_flags got busy=%0b done=%0b status=%0d blank_pos=%0d want all 0", busy, done, status, blank_pos);
    end
    checks++;
    if ({rf_we, rf_src0, rf_src1, rf_dst, rf_data} !== 33'd0) begin
      failures++;
      $display("FAIL reset_rf got we=%0b src0=%h src1=%h dst=%h data=%h want all 0", rf_we, rf_src0, rf_src1, rf_dst, rf_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_accept_up();
    int dc;
    logic [31:0] wm;
    poke(POS, 4); poke(COUNT, 0); poke(MAXD, 10);
    poke(BB + 1, 5); poke(BB + 4, 0);
    run_move(2'd0, dc, wm);
    checks++;
    if (dc !== 8 || status !== 2'd0) begin
      failures++;
      $display("FAIL up_done got cycle=%0d status=%0d want cycle=8 status=0", dc, status);
    end
    checks++;
    if (wm !== 32'h0000_00F0) begin
      failures++;
      $display("FAIL up_we_cycles got %h want 000000f0", wm);
    end
    checks++;
    if (rf[BB + 4] !== 8'd5 || rf[BB + 1] !== 8'd0) begin
      failures++;
      $display("FAIL up_board got cell4=%0d cell1=%0d want cell4=5 cell1=0", rf[BB + 4], rf[BB + 1]);
    end
    checks++;
    if (rf[POS] !== 8'd1 || rf[COUNT] !== 8'd1 || blank_pos !== 4'd1) begin
      failures++;
      $display("FAIL up_regs got pos=%0d count=%0d blank_pos=%0d want 1 1 1", rf[POS], rf[COUNT], blank_pos);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL up_after_done got done=%0b busy=%0b want 0 0", done, busy);
    end
    $display("test_accept_up: cycle=%0d status=%0d", dc, status);
  endtask

  task automatic test_illegal();
    int dc;
    logic [31:0] wm;
    int pos_t [4] = '{0, 2, 7, 1};
    logic [1:0] dir_t [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      poke(POS, pos_t[i]); poke(COUNT, 0); poke(MAXD, 10);
      run_move(dir_t[i], dc, wm);
      checks++;
      if (dc !== 2 || status !== 2'd1 || wm !== 32'd0 || rf[POS] !== pos_t[i][7:0]) begin
        failures++;
        $display("FAIL illegal_%0d got cycle=%0d status=%0d we=%h pos=%0d want 2 1 0 %0d", i, dc, status, wm, rf[POS], pos_t[i]);
      end
      $display("test_illegal: pos=%0d dir=%0d cycle=%0d status=%0d", pos_t[i], dir_t[i], dc, status);
    end
    checks++;
    if (blank_pos !== 4'd1) begin
      failures++;
      $display("FAIL illegal_blank_pos got %0d want 1", blank_pos);
    end
    // legal counterpart: blank at 3 moves right onto 4
    poke(POS, 3); poke(COUNT, 5); poke(BB + 3, 0); poke(BB + 4, 7);
    run_move(2'd1, dc, wm);
    checks++;
    if (dc !== 8 || status !== 2'd0 || rf[POS] !== 8'd4 || rf[COUNT] !== 8'd6 || blank_pos !== 4'd4) begin
      failures++;
      $display("FAIL legal_right got cycle=%0d status=%0d pos=%0d count=%0d bp=%0d want 8 0 4 6 4", dc, status, rf[POS], rf[COUNT], blank_pos);
    end
    checks++;
    if (rf[BB + 3] !== 8'd7 || rf[BB + 4] !== 8'd0) begin
      failures++;
      $display("FAIL legal_right_board got cell3=%0d cell4=%0d want 7 0", rf[BB + 3], rf[BB + 4]);
    end
    $display("test_illegal: legal pos=3 dir=1 cycle=%0d status=%0d", dc, status);
  endtask

  task automatic test_depth();
    int dc;
    logic [31:0] wm;
    poke(POS, 4); poke(COUNT, 10); poke(MAXD, 10); poke(BB + 1, 5); poke(BB + 4, 0);
    run_move(2'd0, dc, wm);
    checks++;
    if (dc !== 3 || status !== 2'd2 || wm !== 32'd0) begin
      failures++;
      $display("FAIL depth got cycle=%0d status=%0d we=%h want 3 2 0", dc, status, wm);
    end
    checks++;
    if (rf[POS] !== 8'd4 || rf[COUNT] !== 8'd10 || rf[BB + 1] !== 8'd5 || rf[BB + 4] !== 8'd0) begin
      failures++;
      $display("FAIL depth_regs got pos=%0d count=%0d c1=%0d c4=%0d want 4 10 5 0", rf[POS], rf[COUNT], rf[BB + 1], rf[BB + 4]);
    end
    $display("test_depth: cycle=%0d status=%0d", dc, status);
  endtask

  task automatic test_bad_pos();
    int dc;
    logic [31:0] wm;
    int pv [2] = '{9, 255};
    for (int i = 0; i < 2; i++) begin
      poke(POS, pv[i]); poke(COUNT, 0); poke(MAXD, 10);
      run_move(2'd2, dc, wm);
      checks++;
      if (dc !== 2 || status !== 2'd3 || wm !== 32'd0) begin
        failures++;
        $display("FAIL bad_pos_%0d got cycle=%0d status=%0d we=%h want 2 3 0", pv[i], dc, status, wm);
      end
      $display("test_bad_pos: pos=%0d cycle=%0d status=%0d", pv[i], dc, status);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    logic [31:0] wm;
    poke(POS, 4); poke(COUNT, 0); poke(MAXD, 10); poke(BB + 1, 5); poke(BB + 4, 0);
    dir = 2'd0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (rf_we !== 1'b1 || rf_dst !== 8'(BB + 4)) begin
      failures++;
      $display("FAIL mid_wr_tile got we=%0b dst=%h want 1 %h", rf_we, rf_dst, 8'(BB + 4));
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0 || status !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got busy=%0b we=%0b done=%0b status=%0d want 0 0 0 0", busy, rf_we, done, status);
    end
    @(negedge clk);
    poke(POS, 4); poke(COUNT, 0); poke(BB + 1, 5); poke(BB + 4, 0);
    run_move(2'd0, dc, wm);
    checks++;
    if (dc !== 8 || status !== 2'd0 || rf[POS] !== 8'd1 || rf[BB + 4] !== 8'd5 || blank_pos !== 4'd1) begin
      failures++;
      $display("FAIL mid_fresh got cycle=%0d status=%0d pos=%0d c4=%0d bp=%0d want 8 0 1 5 1", dc, status, rf[POS], rf[BB + 4], blank_pos);
    end
    $display("test_reset_mid: fresh move cycle=%0d status=%0d", dc, status);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wm, dm;
    logic [7:0] pos_c9;
    wm = 32'd0;
    dm = 32'd0;
    pos_c9 = 8'hEE;
    poke(POS, 4); poke(COUNT, 0); poke(MAXD, 10); poke(BB + 4, 0); poke(BB + 5, 9);
    dir = 2'd1;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 2) dir = 2'd3;
      if (rf_we) wm[c] = 1'b1;
      if (done) dm[c] = 1'b1;
      if (c == 9) begin
        pos_c9 = rf[POS];
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle_c9 got busy=%0b want 0", busy);
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pos_c9 !== 8'd5) begin
      failures++;
      $display("FAIL b2b_first_move got pos=%0d want 5", pos_c9);
    end
    checks++;
    if (dm !== 32'h0002_0100 || wm !== 32'h0001_E0F0) begin
      failures++;
      $display("FAIL b2b_timing got done=%h we=%h want 00020100 0001e0f0", dm, wm);
    end
    checks++;
    if (rf[POS] !== 8'd4 || rf[COUNT] !== 8'd2 || rf[BB + 4] !== 8'd0 || rf[BB + 5] !== 8'd9 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final got pos=%0d count=%0d c4=%0d c5=%0d busy=%0b want 4 2 0 9 0", rf[POS], rf[COUNT], rf[BB + 4], rf[BB + 5], busy);
    end
    $display("test_back_to_back: done=%h we=%h", dm, wm);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_accept_up();
    test_illegal();
    test_depth();
    test_bad_pos();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
